cic_decim: RTL and testbench
============================

# cic_decim

Parametrised CIC decimation filter: ORDER integrator stages at the input rate, a decimate-by-RATE counter, and ORDER comb stages at the output rate. It is the next generation of the fixed single-bit `cic` block. It accepts either 1-bit PDM (mapped to ±1) or signed multi-bit input with a sample-valid qualifier, and emits scaled OW-bit samples with a one-cycle valid strobe. It sits between the PDM/ADC front end and downstream sample processing.

## Interface
- ORDER, 4, number of integrator and comb stages (1..8)
- RATE, 64, decimation factor (2..4096; need not be a power of two)
- IW, 1, input width; IW==1 selects PDM mode (din 1 → +1, 0 → −1), IW>1 is two's-complement
- OW, 24, output width (signed)
- Derived: W = max(IW,2) + ORDER*clog2(RATE) internal width; S = W − OW output shift
- clk  input  1  clock; all state on rising edge
- reset  input  1  asynchronous, active-low reset
- din  input  IW  input sample
- din_valid  input  1  din accepted on any rising edge where high
- dout  output  OW  signed decimated sample
- dout_valid  output  1  single-cycle strobe; dout is new when high

## Operation
- Input mapping: PDM mode sign-extends ±1 to W bits; otherwise din is sign-extended to W bits.
- Integrators: on each accepted sample, stage 0 adds the mapped input and stage k adds the registered stage k−1 value. All arithmetic is modulo 2^W; wrap-around is required and must not saturate.
- Decimation counter: runs 0..RATE−1 and advances only on accepted samples. On an accepted sample with count==RATE−1 it returns to 0 and asserts the internal strobe.
- Combs (strobe edge only): comb 0 = last integrator − its value at the previous strobe; comb k = comb k−1 reg − its previous value. All stages update simultaneously. Modulo 2^W.
- Output: dout = last comb value scaled to OW bits.
  - S>0: arithmetic shift right by S (truncation toward −inf).
  - S<=0: sign-extend.
- Stall: din_valid low freezes integrators, counter and combs. dout holds its value.
- Reset (asserted, at any time including mid-frame): all integrators, combs, counter, dout = 0 and dout_valid = 0. The first strobe occurs after RATE accepted samples following deassertion.

## Timing
- Integrator chain: one accepted-sample delay per stage.
- dout and dout_valid update on the same edge that accepts the RATE-th sample of a frame. dout_valid is high for exactly that one following cycle.
- Back-to-back strobes are at least RATE cycles apart. dout_valid never stays high two consecutive cycles unless RATE... (RATE>=2 forbids it).
- Transient: the first ORDER+1 outputs after reset are start-up transient. Outputs from the (ORDER+2)-th strobe onward are steady state for a constant input.
- No input backpressure: din_valid may be high every cycle.

## Configuration
- CIC_ROUND_EN defined (S>0 only):
  - Adds 2^(S−1) before the shift (round half up).
  - If the rounded result exceeds the maximum positive OW value, dout saturates to 2^(OW−1)−1.
  - Adds no cycles of latency.
- CIC_ROUND_EN undefined: plain truncation as in Operation. No rounding or saturation logic is present.
- S<=0: the macro has no effect.

## Test plan
- Defaults, din=1 and din_valid=1 continuously: dout_valid every 64 cycles. From the 6th strobe onward, dout = 4194304 (2^22).
- Defaults, din=0 continuously: steady dout = −4194304. Alternating din 1,0,1,0: steady dout = 0.
- Defaults, din_valid high every 3rd cycle, din=1: strobes exactly 192 cycles apart; steady dout = 4194304. dout holds between strobes.
- IW=16, OW=14, ORDER=1, RATE=2, din=6 constant: steady dout = 1 without CIC_ROUND_EN, 2 with it. din=−6: −2 without, −1 with.
- Reset asserted for 1 cycle mid-frame (after 30 accepted samples): dout=0 and dout_valid=0 immediately (asynchronously). The next dout_valid occurs exactly 64 accepted samples after reset deasserts.
- ORDER=2, RATE=3, IW=8, OW=12, din=100 constant: W=12, S=0; steady dout = 900.

Source files
------------

// File: rtl/cic_decim.sv
// cic_decim: CIC decimator with ORDER integrators at the input rate, decimate-by-RATE, ORDER combs.
// Define CIC_ROUND_EN for round-half-up with positive saturation on the output shift (S>0 only).
module cic_decim #(
    parameter int ORDER = 4,
    parameter int RATE  = 64,
    parameter int IW    = 1,
    parameter int OW    = 24
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [IW-1:0] din,
    input  logic          din_valid,
    output logic [OW-1:0] dout,
    output logic          dout_valid
);

    localparam int LOG2R = $clog2(RATE);
    localparam int IWX   = (IW > 1) ? IW : 2;
    localparam int W     = IWX + ORDER * LOG2R;
    localparam int S     = W - OW;
    localparam int CW    = (LOG2R > 0) ? LOG2R : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(RATE - 1);

    logic [W-1:0]  x_ext;
    logic [W-1:0]  integ_q [ORDER];
    logic [W-1:0]  integ_d [ORDER];
    logic [W-1:0]  dly_q   [ORDER];
    logic [W-1:0]  dly_d   [ORDER];
    logic [W-1:0]  comb_last;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          strobe;
    logic [OW-1:0] scaled;
    logic [OW-1:0] dout_q, dout_d;
    logic          dout_valid_q, dout_valid_d;

    generate
        if (IW == 1) begin : g_pdm
            // 1 -> +1, 0 -> -1
            assign x_ext = {{(W-1){~din[0]}}, 1'b1};
        end else begin : g_pcm
            assign x_ext = {{(W-IW){din[IW-1]}}, din};
        end
    endgenerate

    always_comb begin
        strobe = din_valid && (cnt_q == CNT_LAST);
        cnt_d  = cnt_q;
        if (din_valid) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_comb begin
        for (int k = 0; k < ORDER; k++) begin
            integ_d[k] = integ_q[k];
        end
        if (din_valid) begin
            integ_d[0] = integ_q[0] + x_ext;
            for (int k = 1; k < ORDER; k++) begin
                integ_d[k] = integ_q[k] + integ_q[k-1];
            end
        end
    end

    // Comb stages are chained combinationally within a strobe; each stage keeps
    // its own input from the previous strobe so the chain adds no output-rate delay.
    always_comb begin : comb_chain
        logic [W-1:0] acc;
        acc = integ_q[ORDER-1];
        for (int k = 0; k < ORDER; k++) begin
            dly_d[k] = strobe ? acc : dly_q[k];
            acc      = acc - dly_q[k];
        end
        comb_last = acc;
    end

    generate
        if (S > 0) begin : g_shift
`ifdef CIC_ROUND_EN
            localparam logic [W:0] HALF = (W+1)'(1) << (S - 1);
            logic [W:0]  rnd;
            logic [OW:0] rsh;
            logic        unused_rnd_lsbs;
            assign rnd             = {comb_last[W-1], comb_last} + HALF;
            assign rsh             = rnd[W:S];
            assign unused_rnd_lsbs = ^rnd[S-1:0];
            // Only a positive overflow is possible after adding the half LSB.
            assign scaled = (!rsh[OW] && rsh[OW-1]) ? {1'b0, {(OW-1){1'b1}}} : rsh[OW-1:0];
`else
            logic unused_lsbs;
            assign scaled      = comb_last[W-1:S];
            assign unused_lsbs = ^comb_last[S-1:0];
`endif
        end else if (S == 0) begin : g_same
            assign scaled = comb_last;
        end else begin : g_extend
            assign scaled = {{(-S){comb_last[W-1]}}, comb_last};
        end
    endgenerate

    always_comb begin
        dout_d       = strobe ? scaled : dout_q;
        dout_valid_d = strobe;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < ORDER; k++) begin
                integ_q[k] <= '0;
                dly_q[k]   <= '0;
            end
            cnt_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            for (int k = 0; k < ORDER; k++) begin
                integ_q[k] <= integ_d[k];
                dly_q[k]   <= dly_d[k];
            end
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_cic_decim.sv
// Directed bench for cic_decim: default PDM build, a 16-bit rounding build and an S=0 build.
module tb_cic_decim;

    logic clk;
    logic reset;

    logic        d_din, d_vld, d_dv;
    logic [23:0] d_dout;
    logic [15:0] r_din;
    logic        r_vld, r_dv;
    logic [13:0] r_dout;
    logic [7:0]  o_din;
    logic        o_vld, o_dv;
    logic [11:0] o_dout;

    int n_checks = 0;
    int n_pass   = 0;

    int          stb_cyc [12];
    logic [23:0] stb_val [12];
    int          nstb;
    bit          held_ok, pulse_ok;

    cic_decim u_def (
        .clk(clk), .reset(reset), .din(d_din), .din_valid(d_vld),
        .dout(d_dout), .dout_valid(d_dv)
    );

    cic_decim #(.ORDER(1), .RATE(2), .IW(16), .OW(14)) u_w16 (
        .clk(clk), .reset(reset), .din(r_din), .din_valid(r_vld),
        .dout(r_dout), .dout_valid(r_dv)
    );

    cic_decim #(.ORDER(2), .RATE(3), .IW(8), .OW(12)) u_o2 (
        .clk(clk), .reset(reset), .din(o_din), .din_valid(o_vld),
        .dout(o_dout), .dout_valid(o_dv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        d_vld = 1'b0;
        r_vld = 1'b0;
        o_vld = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // mode 0: din=1, mode 1: din=0, mode 2: alternate per accepted sample.
    // din_valid is high every vperiod-th cycle; din is inverted while invalid.
    task automatic run_def(input int mode, input int vperiod, input int want);
        logic        cur;
        logic        prev_dv;
        logic [23:0] held;
        int          budget;
        cur      = (mode == 1) ? 1'b0 : 1'b1;
        nstb     = 0;
        held_ok  = 1'b1;
        pulse_ok = 1'b1;
        held     = d_dout;
        prev_dv  = 1'b0;
        for (int k = 0; k < 12; k++) begin
            stb_cyc[k] = -1;
            stb_val[k] = 'x;
        end
        budget = want * 64 * vperiod + 64;
        for (int cyc = 1; cyc <= budget && nstb < want; cyc++) begin
            d_vld = ((cyc % vperiod) == 0);
            d_din = d_vld ? cur : ~cur;
            @(posedge clk);
            #1;
            if (d_vld && mode == 2) cur = ~cur;
            if (d_dv) begin
                if (prev_dv) pulse_ok = 1'b0;
                stb_cyc[nstb] = cyc;
                stb_val[nstb] = d_dout;
                nstb++;
                held = d_dout;
            end else if (d_dout !== held) begin
                held_ok = 1'b0;
            end
            prev_dv = d_dv;
            @(negedge clk);
        end
        d_vld = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        d_vld = 1'b0; r_vld = 1'b0; o_vld = 1'b0;
        d_din = 1'b0; r_din = '0;   o_din = '0;
        #2;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (d_dout !== 24'd0) $display("FAIL reset_def_dout: got %0d want 0", d_dout); else n_pass++;
        n_checks++; if (d_dv !== 1'b0) $display("FAIL reset_def_valid: got %b want 0", d_dv); else n_pass++;
        n_checks++; if (r_dout !== 14'd0) $display("FAIL reset_w16_dout: got %0d want 0", r_dout); else n_pass++;
        n_checks++; if (r_dv !== 1'b0) $display("FAIL reset_w16_valid: got %b want 0", r_dv); else n_pass++;
        n_checks++; if (o_dout !== 12'd0) $display("FAIL reset_o2_dout: got %0d want 0", o_dout); else n_pass++;
        n_checks++; if (o_dv !== 1'b0) $display("FAIL reset_o2_valid: got %b want 0", o_dv); else n_pass++;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++; if (d_dv !== 1'b0) $display("FAIL idle_valid: got %b want 0", d_dv); else n_pass++;
        $display("test_reset done");
    endtask

    task automatic test_pdm_ones();
        apply_reset();
        run_def(0, 1, 8);
        n_checks++; if (nstb !== 8) $display("FAIL ones_strobe_count: got %0d want 8", nstb); else n_pass++;
        n_checks++; if (stb_cyc[0] !== 64) $display("FAIL ones_first_strobe: got %0d want 64", stb_cyc[0]); else n_pass++;
        for (int k = 1; k < 8; k++) begin
            n_checks++;
            if (stb_cyc[k] - stb_cyc[k-1] !== 64)
                $display("FAIL ones_gap%0d: got %0d want 64", k, stb_cyc[k] - stb_cyc[k-1]);
            else n_pass++;
        end
        // First frame after reset: C(63,4) = 595665, shifted right by 2.
        n_checks++; if (stb_val[0] !== 24'd148916) $display("FAIL ones_first_value: got %0d want 148916", $signed(stb_val[0])); else n_pass++;
        for (int k = 5; k < 8; k++) begin
            n_checks++;
            if (stb_val[k] !== 24'd4194304)
                $display("FAIL ones_steady%0d: got %0d want 4194304", k + 1, $signed(stb_val[k]));
            else n_pass++;
        end
        n_checks++; if (pulse_ok !== 1'b1) $display("FAIL ones_single_pulse: got %b want 1", pulse_ok); else n_pass++;
        n_checks++; if (held_ok !== 1'b1) $display("FAIL ones_hold: got %b want 1", held_ok); else n_pass++;
        $display("test_pdm_ones done: %0d strobes", nstb);
    endtask

    task automatic test_pdm_zeros();
        apply_reset();
        run_def(1, 1, 8);
        for (int k = 5; k < 8; k++) begin
            n_checks++;
            if (stb_val[k] !== 24'hC00000)
                $display("FAIL zeros_steady%0d: got %0d want -4194304", k + 1, $signed(stb_val[k]));
            else n_pass++;
        end
        $display("test_pdm_zeros done: %0d strobes", nstb);
    endtask

    task automatic test_pdm_alternating();
        apply_reset();
        run_def(2, 1, 8);
        for (int k = 5; k < 8; k++) begin
            n_checks++;
            if (stb_val[k] !== 24'd0)
                $display("FAIL alt_steady%0d: got %0d want 0", k + 1, $signed(stb_val[k]));
            else n_pass++;
        end
        $display("test_pdm_alternating done: %0d strobes", nstb);
    endtask

    task automatic test_stall();
        apply_reset();
        run_def(0, 3, 7);
        n_checks++; if (stb_cyc[0] !== 192) $display("FAIL stall_first_strobe: got %0d want 192", stb_cyc[0]); else n_pass++;
        for (int k = 1; k < 7; k++) begin
            n_checks++;
            if (stb_cyc[k] - stb_cyc[k-1] !== 192)
                $display("FAIL stall_gap%0d: got %0d want 192", k, stb_cyc[k] - stb_cyc[k-1]);
            else n_pass++;
        end
        for (int k = 5; k < 7; k++) begin
            n_checks++;
            if (stb_val[k] !== 24'd4194304)
                $display("FAIL stall_steady%0d: got %0d want 4194304", k + 1, $signed(stb_val[k]));
            else n_pass++;
        end
        n_checks++; if (held_ok !== 1'b1) $display("FAIL stall_hold: got %b want 1", held_ok); else n_pass++;
        n_checks++; if (pulse_ok !== 1'b1) $display("FAIL stall_single_pulse: got %b want 1", pulse_ok); else n_pass++;
        $display("test_stall done: %0d strobes", nstb);
    endtask

    task automatic test_reset_midframe();
        int found;
        apply_reset();
        run_def(0, 1, 2);
        d_vld = 1'b1;
        d_din = 1'b1;
        repeat (30) begin
            @(posedge clk);
            @(negedge clk);
        end
        n_checks++; if (d_dout === 24'd0) $display("FAIL mid_pre_nonzero: got %0d want nonzero", d_dout); else n_pass++;
        #2;
        reset = 1'b0;
        #1;
        n_checks++; if (d_dout !== 24'd0) $display("FAIL mid_async_dout: got %0d want 0", $signed(d_dout)); else n_pass++;
        n_checks++; if (d_dv !== 1'b0) $display("FAIL mid_async_valid: got %b want 0", d_dv); else n_pass++;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        found = -1;
        for (int cyc = 1; cyc <= 200 && found < 0; cyc++) begin
            d_vld = 1'b1;
            d_din = 1'b1;
            @(posedge clk);
            #1;
            if (d_dv) found = cyc;
            @(negedge clk);
        end
        d_vld = 1'b0;
        n_checks++; if (found !== 64) $display("FAIL mid_next_strobe: got %0d want 64", found); else n_pass++;
        n_checks++; if (d_dout !== 24'd148916) $display("FAIL mid_first_value: got %0d want 148916", $signed(d_dout)); else n_pass++;
        $display("test_reset_midframe done: strobe after %0d samples", found);
    endtask

    task automatic test_round_w16();
        int          nv;
        logic [13:0] exp_pos, exp_neg;
`ifdef CIC_ROUND_EN
        exp_pos = 14'd2;
        exp_neg = 14'h3FFF;
`else
        exp_pos = 14'd1;
        exp_neg = 14'h3FFE;
`endif
        apply_reset();
        r_vld = 1'b1;
        r_din = 16'd6;
        nv = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (r_dv) nv++;
            @(negedge clk);
        end
        n_checks++; if (nv !== 10) $display("FAIL w16_valid_count: got %0d want 10", nv); else n_pass++;
        n_checks++; if (r_dout !== exp_pos) $display("FAIL w16_pos: got %0d want %0d", $signed(r_dout), $signed(exp_pos)); else n_pass++;
        r_din = 16'hFFFA;
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
        end
        n_checks++; if (r_dout !== exp_neg) $display("FAIL w16_neg: got %0d want %0d", $signed(r_dout), $signed(exp_neg)); else n_pass++;
        r_vld = 1'b0;
        $display("test_round_w16 done: dout=%0d", $signed(r_dout));
    endtask

    task automatic test_order2_s0();
        int nv;
        apply_reset();
        o_vld = 1'b1;
        o_din = 8'd100;
        nv = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (o_dv) nv++;
            @(negedge clk);
        end
        o_vld = 1'b0;
        n_checks++; if (nv !== 10) $display("FAIL o2_valid_count: got %0d want 10", nv); else n_pass++;
        n_checks++; if (o_dout !== 12'd900) $display("FAIL o2_steady: got %0d want 900", $signed(o_dout)); else n_pass++;
        $display("test_order2_s0 done: dout=%0d", $signed(o_dout));
    endtask

    initial begin
        test_reset();
        test_pdm_ones();
        test_pdm_zeros();
        test_pdm_alternating();
        test_stall();
        test_reset_midframe();
        test_round_w16();
        test_order2_s0();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
